// File: rtl/mem_pkg.sv
// Shared constants and FSM state type for the DDR3 read-command front end.
package mem_pkg;

    localparam int         BEAT_BYTES     = 64;
    localparam int         PAGE_BYTES     = 4096;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_64B   = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/mem_burst_len_calc.sv
// Length of the next AXI INCR burst: the smallest of the burst cap, the beats
// still to request, and the beats left before the next 4 KB page boundary.
module mem_burst_len_calc
    import mem_pkg::*;
#(
    parameter int CNT_WIDTH       = 33,
    parameter int BEAT_B          = 64,
    parameter int MAX_BURST_BEATS = 64,
    parameter int PAGE_W          = $clog2(PAGE_BYTES)
) (
    input  logic [PAGE_W-1:0]    addr,
    input  logic [CNT_WIDTH-1:0] beats_left,
    output logic [8:0]           burst_beats
);

    logic [PAGE_W:0]    page_room;
    logic [PAGE_W:0]    page_beats;
    logic [CNT_WIDTH-1:0] lim;

    // addr is beat aligned, so the room to the boundary divides exactly.
    always_comb begin
        page_room  = (PAGE_W+1)'(PAGE_BYTES) - {1'b0, addr};
        page_beats = page_room / (PAGE_W+1)'(BEAT_B);
        lim        = CNT_WIDTH'(MAX_BURST_BEATS);
        if (beats_left < lim) begin
            lim = beats_left;
        end
        if (CNT_WIDTH'(page_beats) < lim) begin
            lim = CNT_WIDTH'(page_beats);
        end
        burst_beats = lim[8:0];
    end

endmodule

// File: rtl/mem_rd_burst_splitter.sv
// Splits one byte-granular read command into 4 KB-safe AXI4 INCR bursts,
// bounds outstanding bursts and streams the returned beats with tlast.
module mem_rd_burst_splitter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 8*BEAT_BYTES,
    parameter int ID_WIDTH        = 1,
    parameter int LEN_WIDTH       = 32,
    parameter int MAX_BURST_BEATS = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  mem_clk,
    input  logic                  mem_rst,
    input  logic                  calib_done,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  sts_valid,
    output logic                  sts_error,
    output rd_state_t             dbg_state
);

    localparam int BEAT_B = DATA_WIDTH/8;
    localparam int OFF_W  = $clog2(BEAT_B);
    localparam int PAGE_W = $clog2(PAGE_BYTES);
    localparam int CNT_W  = LEN_WIDTH + 1;
    localparam int OST_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [2:0] AR_SIZE = (BEAT_B == BEAT_BYTES) ? AXI_SIZE_64B : 3'($clog2(BEAT_B));

    rd_state_t             state, state_next;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [CNT_W-1:0]      ar_left, r_left, ar_step;
    logic [CNT_W-1:0]      byte_span, cmd_beats;
    logic [OST_W-1:0]      outstanding;
    logic                  err_sticky;
    logic [8:0]            burst_beats;
    logic                  active, cmd_fire, ar_fire, r_fire, r_final, ar_load;

    // A transfer happens on any channel exactly in a cycle where valid and
    // ready are both high; AR outputs are held unchanged until arready.
    assign active        = (state != ST_IDLE);
    assign cmd_fire      = cmd_valid & cmd_ready;
    assign ar_fire       = m_axi_arvalid & m_axi_arready;
    assign m_axi_rready  = m_axis_tready & active;
    assign m_axis_tvalid = m_axi_rvalid & active;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tlast  = (r_left == CNT_W'(1));
    assign r_fire        = m_axi_rvalid & m_axi_rready;
    assign r_final       = r_fire & (r_left == CNT_W'(1));
    assign ar_step       = CNT_W'(m_axi_arlen) + CNT_W'(1);
    assign m_axi_arid    = '0;
    assign m_axi_arsize  = AR_SIZE;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign dbg_state     = state;

    // Beat count including the partial leading beat, without overflow.
    assign byte_span = CNT_W'(cmd_addr[OFF_W-1:0]) + CNT_W'(cmd_len);
    assign cmd_beats = (byte_span >> OFF_W) + CNT_W'(|byte_span[OFF_W-1:0]);

    mem_burst_len_calc #(
        .CNT_WIDTH       (CNT_W),
        .BEAT_B          (BEAT_B),
        .MAX_BURST_BEATS (MAX_BURST_BEATS),
        .PAGE_W          (PAGE_W)
    ) u_len_calc (
        .addr        (cur_addr[PAGE_W-1:0]),
        .beats_left  (ar_left),
        .burst_beats (burst_beats)
    );

    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        ar_load    = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = calib_done;
                if (cmd_valid && calib_done && (cmd_len != '0)) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ar_load = !m_axi_arvalid && (ar_left != '0) &&
                          (outstanding < OST_W'(MAX_OUTSTANDING));
                if (ar_fire && (ar_left == ar_step)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_next = ST_DRAIN;
            end
            default: state_next = ST_IDLE;
        endcase
        if (r_final) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            cur_addr      <= '0;
            ar_left       <= '0;
            r_left        <= '0;
            outstanding   <= '0;
            err_sticky    <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            sts_valid     <= 1'b0;
            sts_error     <= 1'b0;
        end else begin
            sts_valid <= 1'b0;
            if (cmd_fire) begin
                cur_addr   <= {cmd_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                ar_left    <= cmd_beats;
                r_left     <= cmd_beats;
                err_sticky <= 1'b0;
                if (cmd_len == '0) begin
                    sts_valid <= 1'b1;
                    sts_error <= 1'b0;
                end
            end
            if (ar_load) begin
                m_axi_arvalid <= 1'b1;
                m_axi_araddr  <= cur_addr;
                m_axi_arlen   <= 8'(burst_beats - 9'd1);
            end else if (ar_fire) begin
                m_axi_arvalid <= 1'b0;
                cur_addr      <= cur_addr + (ADDR_WIDTH'(ar_step) << OFF_W);
                ar_left       <= ar_left - ar_step;
            end
            if (r_fire) begin
                r_left     <= r_left - CNT_W'(1);
                err_sticky <= err_sticky | (m_axi_rresp != 2'b00);
                if (r_final) begin
                    sts_valid <= 1'b1;
                    sts_error <= err_sticky | (m_axi_rresp != 2'b00);
                end
            end
            // A burst issued and a burst retired in the same cycle cancel out.
            case ({ar_fire, r_fire & m_axi_rlast})
                2'b10:   outstanding <= outstanding + OST_W'(1);
                2'b01:   if (outstanding != '0) outstanding <= outstanding - OST_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule
